// File: rtl/radio_mapper_pkg.sv
// rtl/radio_mapper_pkg.sv - shared symbol-width and Gray helpers for mappers
//
// Purpose:
//   Common definitions used by the transmit-side mappers and their helpers.
//   sym_width(M) gives the bits per symbol for a constellation of size M.
//   bin2gray() converts a binary symbol to Gray code. It works on a
//   MAX_SYM_W-wide vector. Narrower callers zero-extend the input and
//   truncate the result. The zero upper bits stay zero through the XOR.
// Ports: none (package).

package radio_mapper_pkg;

  // Widest symbol any mapper in this path is expected to carry.
  localparam int MAX_SYM_W = 16;

  // Bits per symbol. Degenerate sizes map to 1 so port widths stay legal
  // long enough for the elaboration check in the mapper to report them.
  function automatic int sym_width(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Gray code: each output bit is the XOR of a bin bit and its left neighbour.
  function automatic logic [MAX_SYM_W-1:0] bin2gray(input logic [MAX_SYM_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - combinational binary-to-Gray converter, mirror of gray2bin
//
// Purpose:
//   Converts a K-bit binary symbol to Gray code, where K = log2(MODULATION_ORDER).
//   This is the exact inverse of the receive-side gray2bin block.
// Ports:
//   bin   input  K  binary symbol
//   gray  output K  Gray-coded symbol

module bin2gray
  import radio_mapper_pkg::*;
#(
  parameter  int MODULATION_ORDER = 16,
  localparam int K                = sym_width(MODULATION_ORDER)
) (
  input  logic [K-1:0] bin,
  output logic [K-1:0] gray
);

  assign gray = K'(radio_mapper_pkg::bin2gray(MAX_SYM_W'(bin)));

endmodule

// File: rtl/bits2gray_mapper.sv
// rtl/bits2gray_mapper.sv - serial bit packer and Gray encoder feeding the constellation mapper
//
// Purpose:
//   Collects serial bits MSB-first into K-bit symbols and Gray-encodes each
//   completed symbol. Symbols are presented downstream over a valid/ready
//   handshake. i_sof realigns the symbol boundary, and a partial symbol that
//   is discarded this way is reported on o_drop. i_flush zero-pads and emits
//   a pending partial symbol.
// Ports:
//   clk          input  1  system clock
//   rst          input  1  synchronous active-high reset
//   i_bit        input  1  serial data bit
//   i_dv         input  1  i_bit valid
//   i_sof        input  1  i_bit is first bit of a frame (realign)
//   i_flush      input  1  zero-pad and emit the pending partial symbol
//   o_ready      output 1  mapper accepts i_bit / i_sof / i_flush this cycle
//   o_gray_code  output K  Gray-coded symbol
//   o_dv         output 1  o_gray_code valid
//   i_ready      input  1  downstream accepts symbol
//   o_drop       output 1  one-cycle pulse: partial symbol discarded by i_sof

module bits2gray_mapper
  import radio_mapper_pkg::*;
#(
  parameter  int MODULATION_ORDER = 16,
  localparam int K                = sym_width(MODULATION_ORDER)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_bit,
  input  logic         i_dv,
  input  logic         i_sof,
  input  logic         i_flush,
  output logic         o_ready,
  output logic [K-1:0] o_gray_code,
  output logic         o_dv,
  input  logic         i_ready,
  output logic         o_drop
);

  // Counter must be able to hold K itself for the "symbol complete" compare.
  localparam int             CW      = $clog2(K + 1);
  localparam logic [CW-1:0]  K_CNT   = CW'(K);
  localparam logic [K-1:0]   MSB_ONE = K'(1) << (K - 1);

  if (MODULATION_ORDER < 2 || (MODULATION_ORDER & (MODULATION_ORDER - 1)) != 0) begin : g_bad_order
    $error("bits2gray_mapper: MODULATION_ORDER must be a power of 2 and >= 2");
  end
  if (K > MAX_SYM_W) begin : g_too_wide
    $error("bits2gray_mapper: symbol width exceeds MAX_SYM_W");
  end

  logic [K-1:0]  shreg;      // partial symbol, bits already in their final positions
  logic [CW-1:0] cnt;        // bits collected so far, 0..K-1

  logic          bit_acc;
  logic [K-1:0]  base_bin;
  logic [CW-1:0] base_cnt;
  logic [K-1:0]  pos;
  logic [K-1:0]  new_bin;
  logic [CW-1:0] cnt_after;
  logic          complete;
  logic          flush_emit;
  logic          emit;
  logic [K-1:0]  gray_next;

  // Only the output register decides readiness, so an emit can never
  // overwrite a symbol that is still waiting for the downstream.
  assign o_ready = !o_dv || i_ready;

  always_comb begin
    bit_acc   = i_dv && o_ready;
    base_bin  = shreg;
    base_cnt  = cnt;
    // A realigning bit starts from an empty symbol.
    if (bit_acc && i_sof) begin
      base_bin = '0;
      base_cnt = '0;
    end
    // Each bit is dropped straight into its final position. Unfilled LSBs
    // stay zero, so a flushed symbol is already zero-padded.
    pos       = MSB_ONE >> base_cnt;
    new_bin   = base_bin;
    cnt_after = base_cnt;
    if (bit_acc) begin
      if (i_bit) begin
        new_bin = base_bin | pos;
      end
      cnt_after = base_cnt + 1'b1;
    end
    complete   = bit_acc && (cnt_after == K_CNT);
    // A flush emits only when something remains after the incoming bit is
    // taken in. For K=1 every accepted bit completes, so this never fires.
    flush_emit = o_ready && i_flush && !complete && (cnt_after != '0);
    emit       = complete || flush_emit;
  end

  bin2gray #(
    .MODULATION_ORDER(MODULATION_ORDER)
  ) u_bin2gray (
    .bin  (new_bin),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      cnt         <= '0;
      o_gray_code <= '0;
      o_dv        <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      o_drop <= bit_acc && i_sof && (cnt != '0);
      if (emit) begin
        // Also covers back-to-back drain: a held symbol transferring this
        // cycle is replaced, and o_dv stays high.
        shreg       <= '0;
        cnt         <= '0;
        o_gray_code <= gray_next;
        o_dv        <= 1'b1;
      end else begin
        shreg <= new_bin;
        cnt   <= cnt_after;
        if (i_ready) begin
          o_dv <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bits2gray_mapper.sv
// tb/tb_bits2gray_mapper.sv - self-checking bench for bits2gray_mapper (M=16 and M=2)

module tb_bits2gray_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] t_bit, t_dv, t_sof, t_flush, t_rdy;
  logic [1:0] d_ready, d_dv, d_drop;
  logic [3:0] g16;
  logic [0:0] g2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference state: the partial symbol is kept as an integer value plus a bit count.
  int m_val [2];
  int m_cnt [2];
  int m_gray[2];
  bit m_dv  [2];
  bit m_drop[2];

  bits2gray_mapper #(.MODULATION_ORDER(16)) dut16 (
    .clk(clk), .rst(rst), .i_bit(t_bit[0]), .i_dv(t_dv[0]), .i_sof(t_sof[0]),
    .i_flush(t_flush[0]), .o_ready(d_ready[0]), .o_gray_code(g16), .o_dv(d_dv[0]),
    .i_ready(t_rdy[0]), .o_drop(d_drop[0])
  );

  bits2gray_mapper #(.MODULATION_ORDER(2)) dut2 (
    .clk(clk), .rst(rst), .i_bit(t_bit[1]), .i_dv(t_dv[1]), .i_sof(t_sof[1]),
    .i_flush(t_flush[1]), .o_ready(d_ready[1]), .o_gray_code(g2), .o_dv(d_dv[1]),
    .i_ready(t_rdy[1]), .o_drop(d_drop[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int  k;
    int  bin;
    bit  rdy;
    k   = (i == 0) ? 4 : 1;
    rdy = !m_dv[i] || t_rdy[i];
    if (rst) begin
      m_val[i] = 0; m_cnt[i] = 0; m_gray[i] = 0; m_dv[i] = 0; m_drop[i] = 0;
      return;
    end
    m_drop[i] = 0;
    if (rdy && t_dv[i]) begin
      if (t_sof[i]) begin
        m_drop[i] = (m_cnt[i] != 0);
        m_val[i]  = 0;
        m_cnt[i]  = 0;
      end
      m_val[i] = m_val[i] * 2 + int'(t_bit[i]);
      m_cnt[i]++;
    end
    if (m_cnt[i] == k || (rdy && t_flush[i] && m_cnt[i] > 0)) begin
      bin       = m_val[i] << (k - m_cnt[i]);
      m_gray[i] = bin ^ (bin >> 1);
      m_dv[i]   = 1;
      m_val[i]  = 0;
      m_cnt[i]  = 0;
    end else if (m_dv[i] && t_rdy[i]) begin
      m_dv[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m16_dv", d_dv[0], m_dv[0]);
      chk("m16_drop", d_drop[0], m_drop[0]);
      chk("m16_ready", d_ready[0], !m_dv[0] || t_rdy[0]);
      if (m_dv[0]) chk("m16_gray", g16, m_gray[0]);
      chk("m2_dv", d_dv[1], m_dv[1]);
      chk("m2_drop", d_drop[1], m_drop[1]);
      chk("m2_ready", d_ready[1], !m_dv[1] || t_rdy[1]);
      if (m_dv[1]) chk("m2_gray", g2, m_gray[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit16(input logic b, input logic sof = 1'b0, input logic fl = 1'b0);
    t_bit[0] = b; t_dv[0] = 1'b1; t_sof[0] = sof; t_flush[0] = fl;
    step();
  endtask

  task automatic idle16();
    t_dv[0] = 1'b0; t_sof[0] = 1'b0; t_flush[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    t_bit = '0; t_dv = '0; t_sof = '0; t_flush = '0; t_rdy = 2'b11;
    step(); step();
    chk("reset_dv16", d_dv[0], 0);
    chk("reset_gray16", g16, 0);
    chk("reset_drop16", d_drop[0], 0);
    chk("reset_dv2", d_dv[1], 0);
    chk("reset_gray2", g2, 0);
    cmp_en = 1'b1;
    rst = 1'b0;

    // 1,0,1,1 -> bin 1011 -> gray 1110, valid for one cycle
    bit16(1); bit16(0); bit16(1);
    chk("basic_not_early", d_dv[0], 0);
    bit16(1);
    chk("basic_dv", d_dv[0], 1);
    chk("basic_gray", g16, 4'b1110);
    idle16(); step();
    chk("basic_one_cycle", d_dv[0], 0);

    // Backpressure: hold 1110 while bits are refused, then 0,0,1,1 -> 0010
    bit16(1); bit16(0); bit16(1); bit16(1);
    t_rdy[0] = 1'b0; t_bit[0] = 1'b0; t_dv[0] = 1'b1;
    step();
    chk("bp_ready_low", d_ready[0], 0);
    chk("bp_hold_dv", d_dv[0], 1);
    chk("bp_hold_gray", g16, 4'b1110);
    step();
    chk("bp_hold_gray2", g16, 4'b1110);
    t_rdy[0] = 1'b1; idle16(); step();
    chk("bp_transferred", d_dv[0], 0);
    bit16(0); bit16(0); bit16(1); bit16(1);
    chk("bp_next_dv", d_dv[0], 1);
    chk("bp_next_gray", g16, 4'b0010);
    idle16(); step();

    // Flush: 1,1 + flush -> 1100 -> 1010; then 0,1,0,1 fresh -> 0111
    bit16(1); bit16(1);
    idle16(); t_flush[0] = 1'b1; step();
    chk("flush_dv", d_dv[0], 1);
    chk("flush_gray", g16, 4'b1010);
    bit16(0); bit16(1); bit16(0);
    chk("flush_fresh_not_early", d_dv[0], 0);
    bit16(1);
    chk("flush_fresh_gray", g16, 4'b0111);
    idle16(); step();

    // SOF realign: 1,0 discarded; 0(sof),1,1,1 -> 0111 -> 0100
    bit16(1); bit16(0); bit16(0, 1'b1);
    chk("sof_drop", d_drop[0], 1);
    chk("sof_no_symbol", d_dv[0], 0);
    bit16(1);
    chk("sof_drop_pulse", d_drop[0], 0);
    bit16(1); bit16(1);
    chk("sof_dv", d_dv[0], 1);
    chk("sof_gray", g16, 4'b0100);
    idle16(); step();

    // SOF with flush: 1,0 dropped, new bit 1 flushed -> 1000 -> 1100
    bit16(1); bit16(0); bit16(1, 1'b1, 1'b1);
    chk("sofflush_drop", d_drop[0], 1);
    chk("sofflush_gray", g16, 4'b1100);
    idle16(); step();

    // Flush with a completing bit emits exactly one symbol: 1110 -> 1001
    bit16(1); bit16(1); bit16(1); bit16(0, 1'b0, 1'b1);
    chk("flushfull_gray", g16, 4'b1001);
    idle16(); step();
    chk("flushfull_no_extra", d_dv[0], 0);

    // Reset mid-symbol: no drop, outputs zero, then 1111 -> 1000
    bit16(1); bit16(0); bit16(1);
    idle16(); rst = 1'b1; step();
    chk("rst_mid_dv", d_dv[0], 0);
    chk("rst_mid_gray", g16, 0);
    chk("rst_mid_drop", d_drop[0], 0);
    rst = 1'b0;
    bit16(1); bit16(1); bit16(1); bit16(1);
    chk("rst_after_drop", d_drop[0], 0);
    chk("rst_after_gray", g16, 4'b1000);
    idle16(); step();

    // M=2: each bit is its own symbol, one cycle later
    t_dv[1] = 1'b1; t_bit[1] = 1'b1; step();
    chk("m2_b0_dv", d_dv[1], 1);
    chk("m2_b0_gray", g2, 1);
    t_bit[1] = 1'b0; step();
    chk("m2_b1_gray", g2, 0);
    t_bit[1] = 1'b1; step();
    chk("m2_b2_gray", g2, 1);
    t_dv[1] = 1'b0; step();
    chk("m2_idle_dv", d_dv[1], 0);

    // Randomized traffic on both instances, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        t_dv[i]    = ($urandom_range(0, 3) != 0);
        t_bit[i]   = $urandom_range(0, 1);
        t_sof[i]   = ($urandom_range(0, 15) == 0);
        t_flush[i] = ($urandom_range(0, 15) == 0);
        t_rdy[i]   = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; t_dv = '0; t_sof = '0; t_flush = '0; t_rdy = 2'b11;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bits2gray_mapper.md
Name: bits2gray_mapper

Overview:
- Transmit-side bit-to-symbol packer and Gray encoder; the counterpart of the receive-side gray2bin path.
- Collects a serial bit stream MSB-first into K = $clog2(MODULATION_ORDER)-bit symbols and Gray-encodes each symbol.
- Presents symbols to the modulator over a valid/ready handshake with backpressure.
- Sits between the scrambler/FEC bit output and the constellation mapper.

Parameters:
- MODULATION_ORDER, 16, constellation size; power of 2, >= 2; K = $clog2(MODULATION_ORDER) bits per symbol.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_bit  input  1  serial data bit
- i_dv  input  1  i_bit valid
- i_sof  input  1  qualifies i_bit as first bit of a frame; realigns symbol boundary
- i_flush  input  1  pad the pending partial symbol with zeros and emit it
- o_ready  output  1  mapper accepts i_bit / i_sof / i_flush this cycle
- o_gray_code  output  K  Gray-coded symbol
- o_dv  output  1  o_gray_code valid
- i_ready  input  1  downstream accepts symbol
- o_drop  output  1  one-cycle pulse: partial symbol discarded by i_sof

Behaviour:
- Clock and reset: single clock domain clk; rst is synchronous and active-high, sampled on rising clk.
- Reset values: o_dv=0, o_gray_code=0, o_drop=0, bit counter cnt=0, shift register=0. Reset mid-symbol silently discards partial bits (no o_drop).
- Handshake:
  - o_ready = !o_dv || i_ready (combinational from i_ready and the output register only).
  - Bit accepted when i_dv && o_ready.
  - i_sof and i_flush are ignored when o_ready=0.
  - Output symbol transfers when o_dv && i_ready.
  - o_gray_code and o_dv are held stable while o_dv && !i_ready.
- Packing:
  - Accepted bits shift in MSB-first.
  - cnt counts 0..K-1 and wraps to 0 when a symbol completes.
  - First accepted bit becomes bin[K-1]; the K-th becomes bin[0].
- Encoding: gray = bin ^ (bin >> 1); exact inverse of gray2bin.
- Latency: o_dv asserts on the cycle after the clock edge that accepts the completing bit; the output is registered. Full throughput: one symbol per K cycles with no bubbles when i_ready=1.
- Back-to-back drain: if a new symbol completes in the same cycle the held symbol transfers, the output register reloads and o_dv stays 1.
- i_sof (accepted with a bit):
  - If cnt != 0, the partial symbol is discarded and o_drop pulses for one cycle on the next cycle.
  - The accompanying bit is loaded as bin[K-1] and cnt becomes 1.
  - If cnt == 0, no o_drop.
- i_flush (sampled when o_ready=1):
  - With i_dv=1 in the same cycle, the bit is included first.
  - If the resulting cnt != 0, the remaining LSBs are zero-padded, the symbol is emitted with normal latency, and cnt returns to 0.
  - If the resulting cnt == 0 (empty, or the bit just completed a symbol), nothing extra is emitted.
- i_sof and i_flush together: i_sof takes precedence for realignment. The new bit is the MSB of a symbol that is then flushed with zero padding.
- K=1 (MODULATION_ORDER=2): every accepted bit is a symbol; gray = bin; i_flush is a no-op; o_drop never pulses.
- Invalid parameters: non-power-of-2 MODULATION_ORDER or MODULATION_ORDER < 2 fails an elaboration-time assertion.

Decomposition:
- Shared package radio_mapper_pkg:
  - localparam function sym_width(M) returning $clog2(M)
  - pure function bin2gray(logic [K-1:0]) for use by mappers
- Optional combinational sub-module bin2gray #(MODULATION_ORDER), the mirror of gray2bin.
- Packer, counter and output register stay in bits2gray_mapper.
- No interface bundle is required.

Test Plan:
- M=16, i_ready=1, bits 1,0,1,1 on consecutive cycles -> bin 1011, o_gray_code=1110, o_dv=1 for exactly one cycle, one cycle after the 4th bit.
- Backpressure: after 1110 is presented hold i_ready=0 and drive bits 0,0,1,1 -> o_ready=0, 1110 held stable; raise i_ready one cycle -> 1110 transfers; then 0,0,1,1 are accepted -> o_gray_code=0010.
- Flush: bits 1,1 then i_flush (i_dv=0) -> bin 1100, o_gray_code=1010; the following 4 bits start a fresh symbol at cnt=0.
- SOF realign: bits 1,0, then i_sof with bit 0, then bits 1,1,1 -> o_drop pulses once; next symbol bin 0111 -> o_gray_code=0100; no symbol from 1,0.
- Reset mid-symbol: 3 bits, pulse rst for one cycle, then bits 1,1,1,1 -> no o_drop, o_gray_code=1000; all outputs 0 during reset.
- M=2: bits 1,0,1 with i_ready=1 -> o_gray_code 1,0,1 on three consecutive cycles, each one cycle after its bit.
